// File: rtl/pipe_issue.sv
// pipe_issue: hazard-checked instruction issue sequencer feeding the ALU/register-bank pipeline.
// Define STALL_COUNT_EN to add the stall_cnt bubble counter output.
module pipe_issue #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int HAZ_WIN = 2,
  parameter int DRAIN_CYC = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [23:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic [3:0]    rs1,
  output logic [3:0]    rs2,
  output logic [3:0]    rd,
  output logic [3:0]    func,
  output logic [7:0]    addr,
  output logic          issue_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [23:0] mem_q [DEPTH];
  logic [23:0] word_q, ins;
  logic [4:0] sb_q [1:HAZ_WIN];
  logic [AW-1:0] pc_q;
  logic [7:0] cnt_q;
  logic issue_valid_q, done_q, haz, issue, last, accept, drain_end;
  always_comb begin
    ins = mem_q[pc_q];
    haz = 1'b0;
    for (int k = 1; k <= HAZ_WIN; k++)
      haz = haz | (sb_q[k][4] && (sb_q[k][3:0] == ins[15:12] || sb_q[k][3:0] == ins[11:8]));
    issue = (state_q == RUN) && !haz;
    last = ({1'b0, pc_q} + (AW+1)'(1)) == prog_len;
    accept = (state_q == IDLE) && start;
    drain_end = (state_q == DRAIN) && (cnt_q == 8'(DRAIN_CYC - 1));
    state_d = state_q;
    if (accept) state_d = (prog_len != '0) ? RUN : DRAIN;
    if (issue && last) state_d = DRAIN;
    if (drain_end) state_d = IDLE;
  end
  // program memory is deliberately not reset and only writable while idle
  always_ff @(posedge clk)
    if (prog_we && state_q == IDLE) mem_q[prog_addr] <= prog_data;
  // scoreboard is held clear while idle so every run starts hazard-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q <= '0;
      issue_valid_q <= 1'b0;
      done_q <= 1'b0;
      pc_q <= '0;
      cnt_q <= '0;
      for (int k = 1; k <= HAZ_WIN; k++) sb_q[k] <= '0;
    end else begin
      state_q <= state_d;
      issue_valid_q <= issue;
      done_q <= drain_end;
      cnt_q <= (state_q == DRAIN) ? cnt_q + 8'd1 : '0;
      if (issue) word_q <= ins;
      pc_q <= accept ? '0 : issue ? pc_q + AW'(1) : pc_q;
      sb_q[1] <= (state_q == IDLE) ? '0 : {issue, ins[19:16]};
      for (int k = 2; k <= HAZ_WIN; k++) sb_q[k] <= (state_q == IDLE) ? '0 : sb_q[k-1];
    end
  end
  assign func = word_q[23:20];
  assign rd = word_q[19:16];
  assign rs1 = word_q[15:12];
  assign rs2 = word_q[11:8];
  assign addr = word_q[7:0];
  assign issue_valid = issue_valid_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
  assign pc = pc_q;
`ifdef STALL_COUNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst || accept) stall_q <= '0;
    else if (state_q == RUN && haz && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: doc/pipe_issue.md
Name: pipe_issue

Overview:
Instruction issue sequencer that drives the operand/command inputs of the pipelined ALU–register-bank block: rs1, rs2, rd, func and addr.
- Holds a small program memory loaded over a write port.
- On start, issues one instruction per clock with a register read-after-write hazard check, inserting bubbles where needed.
- Waits a fixed drain time after the last issue, then pulses done.
- Sits between the controller/bench and the pipeline, replacing hand-timed stimulus.

Parameters:
DEPTH, 16, program memory entries
AW, 4, program address width (DEPTH = 2**AW)
HAZ_WIN, 2, number of previous issue slots checked for rd conflicts (1..4)
DRAIN_CYC, 3, cycles after last issue before done

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
prog_we  in  1  program memory write enable
prog_addr  in  AW  program write address
prog_data  in  24  instruction word: [23:20]=func, [19:16]=rd, [15:12]=rs1, [11:8]=rs2, [7:0]=addr
prog_len  in  AW+1  number of instructions to issue (0..DEPTH)
start  in  1  begin issue from entry 0; sampled in IDLE only
rs1  out  4  source register 1 to pipeline
rs2  out  4  source register 2 to pipeline
rd  out  4  destination register to pipeline
func  out  4  ALU function code to pipeline
addr  out  8  memory write address to pipeline
issue_valid  out  1  high in cycles where output fields carry a new instruction
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at end of program
pc  out  AW  index of next instruction to issue

Behaviour:
Reset and program load:
- Reset (synchronous, active-high):
  - state=IDLE.
  - All outputs 0: rs1, rs2, rd, func, addr, issue_valid, busy, done, pc.
  - Scoreboard cleared.
  - Program memory contents not cleared.
  - Reset mid-RUN/DRAIN aborts immediately; the next cycle is IDLE with the above values.
- prog_we is honoured only in IDLE; writes while busy are dropped.

FSM:
- IDLE:
  - start=1 with prog_len>0 → RUN, pc=0.
  - start=1 with prog_len=0 → DRAIN directly.
- RUN, each cycle, take entry prog_mem[pc]:
  - Hazard: its rs1 or rs2 equals rd of any valid scoreboard slot sb[1..HAZ_WIN].
  - No hazard → register all fields onto the outputs, issue_valid=1, pc+1.
  - Hazard → issue_valid=0, output fields hold previous values, pc unchanged (bubble).
  - When the issued instruction is entry prog_len-1 → DRAIN.
- DRAIN:
  - Counts DRAIN_CYC cycles with issue_valid=0.
  - Then done=1 for exactly one cycle together with the transition to IDLE; busy=0 from that cycle.
- start while busy is ignored.

Scoreboard:
- Every cycle in RUN/DRAIN: sb[1] <= {issued? 1:0, rd of issued}; sb[k] <= sb[k-1].
- Bubbles push an invalid slot.
- Cleared on entry to RUN.

Timing and boundaries:
- Latency: start sampled at edge N; first issue_valid=1 after edge N+1.
- rd==rs1 of the same instruction is not a hazard; only earlier slots are checked.
- prog_len=DEPTH: pc wraps to 0 after last issue; no further issue.

Optional Feature:
STALL_COUNT_EN:
- Defined:
  - Adds output stall_cnt [15:0], counting bubble cycles in RUN.
  - Cleared on start acceptance and on reset.
  - Saturates at 16'hFFFF.
  - Value held after done until the next start.
- Undefined: no port, no counter logic.

Test Plan:
1. Load SUM {0,10,3,5,125}, MUL {2,12,3,8,126}, SUB {1,14,10,5,128}, SLA {11,13,7,3,127}; prog_len=4; start at cycle 0 → issues at cycles 1,2,4,5. SUB is stalled at cycle 3 because rd=10 is in sb[2]. done pulses at cycle 8. With STALL_COUNT_EN, stall_cnt=1.
2. Four independent instructions with no register overlap → issue_valid high for 4 consecutive cycles, zero bubbles, done 3 cycles after the last issue.
3. Back-to-back dependency: instruction 0 with rd=5, instruction 1 reading rs2=5, HAZ_WIN=2 → 2 bubbles, instruction 1 issued 3 cycles after instruction 0.
4. prog_len=0, start → no issue_valid, busy high 3 cycles, single done pulse.
5. Assert rst in the cycle after the second issue → next cycle all outputs 0, state IDLE. A new start then reissues from entry 0.
6. prog_we and a second start pulsed while busy → program memory unchanged, issue sequence unaffected, exactly one done pulse.
